// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4 write master: FSM state encoding,
// burst/response codes and the width of the beat counter.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // AXI4 bursts are at most 256 beats, so an 8-bit count always suffices.
    localparam int BEAT_CNT_W = 8;

    function automatic logic [BEAT_CNT_W-1:0] clamp_len(input logic [7:0] len, input int max_beats);
        if (int'(len) > max_beats - 1) begin
            return BEAT_CNT_W'(max_beats - 1);
        end
        return len;
    endfunction

endpackage

// File: rtl/axi_wr_strb_gen.sv
// Per-beat WSTRB generator: enables the (1<<size)-byte container that holds
// the running address, with the low size bits of the offset forced to zero.
module axi_wr_strb_gen #(
    parameter  int DATA_W = 64,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1
) (
    input  logic [2:0]        i_size,
    input  logic [OFF_W-1:0]  i_addr_off,
    output logic [STRB_W-1:0] o_strb
);

    logic [31:0] w_nbytes;
    logic [31:0] w_off;

    assign w_nbytes = 32'd1 << i_size;
    assign w_off    = 32'(i_addr_off) & 32'(STRB_W - 1) & ~(w_nbytes - 32'd1);

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign o_strb[gi] = (32'(gi) >= w_off) && (32'(gi) < w_off + w_nbytes);
        end
    endgenerate

endmodule

// File: rtl/axi_wr_master.sv
// AXI4 write master: one request becomes one INCR burst (AW, W beats, B).
// Optional AXI_WR_ALIGN_CHECK_EN rejects misaligned / 4 KiB-crossing requests with SLVERR.
module axi_wr_master
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MAX_BEATS = 16,
    parameter int TXN_ID    = 0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [7:0]          req_len,
    input  logic [2:0]          req_size,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [ID_W-1:0]     AWID,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,
    input  logic [ID_W-1:0]     BID
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

    wr_state_e              r_state;
    wr_state_e              w_state_next;
    logic                   r_req_ready;
    logic                   r_awvalid;
    logic [ADDR_W-1:0]      r_awaddr;
    logic [7:0]             r_awlen;
    logic [2:0]             r_awsize;
    logic [1:0]             r_awburst;
    logic [ID_W-1:0]        r_awid;
    logic [BEAT_CNT_W-1:0]  r_len;
    logic [BEAT_CNT_W-1:0]  r_cnt;
    logic [2:0]             r_size;
    logic [OFF_W-1:0]       r_run_off;
    logic                   r_bready;
    logic                   r_done;
    logic [1:0]             r_done_resp;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_last;
    logic                   w_req_err;
    logic                   w_err_next;
    logic [BEAT_CNT_W-1:0]  w_len_clamped;
    logic [STRB_W-1:0]      w_strb;

    assign w_accept      = req_valid && r_req_ready;
    assign w_aw_hs       = (r_state == ST_ADDR) && AWREADY;
    assign w_w_hs        = (r_state == ST_DATA) && wd_valid && WREADY;
    assign w_b_hs        = (r_state == ST_RESP) && r_bready && BVALID;
    assign w_last        = (r_cnt == r_len);
    assign w_len_clamped = clamp_len(req_len, MAX_BEATS);
    assign w_err_next    = w_accept ? w_req_err : r_err;

`ifdef AXI_WR_ALIGN_CHECK_EN
    logic [7:0]  w_align_mask;
    logic [15:0] w_span_end;

    assign w_align_mask = (8'd1 << req_size) - 8'd1;
    // One past the last byte, relative to the start of the 4 KiB page.
    assign w_span_end   = 16'(req_addr[11:0]) + ((16'(w_len_clamped) + 16'd1) << req_size);
    assign w_req_err    = (|(req_addr[7:0] & w_align_mask)) || (w_span_end > 16'd4096);
`else
    assign w_req_err    = 1'b0;
`endif

    axi_wr_strb_gen #(.DATA_W(DATA_W)) u_strb_gen (
        .i_size     (r_size),
        .i_addr_off (r_run_off),
        .o_strb     (w_strb)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_req_err ? ST_RESP : ST_ADDR;
            ST_ADDR: if (AWREADY) w_state_next = ST_DATA;
            ST_DATA: if (w_w_hs && w_last) w_state_next = ST_RESP;
            ST_RESP: if (r_err || (BVALID && r_bready)) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The W channel is a straight pass-through of the source while bursting.
    always_comb begin
        WVALID   = 1'b0;
        WDATA    = '0;
        WSTRB    = '0;
        WLAST    = 1'b0;
        wd_ready = 1'b0;
        if (r_state == ST_DATA) begin
            WVALID   = wd_valid;
            WDATA    = wd_data;
            WSTRB    = w_strb;
            WLAST    = w_last;
            wd_ready = WREADY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_req_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_awburst   <= '0;
            r_awid      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_run_off   <= '0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_done_resp <= AXI_RESP_OKAY;
            r_err       <= 1'b0;
        end else begin
            r_req_ready <= (w_state_next == ST_IDLE);
            r_bready    <= (w_state_next == ST_RESP) && !w_err_next;
            r_err       <= w_err_next;

            if (w_accept) begin
                r_len     <= w_len_clamped;
                r_size    <= req_size;
                r_cnt     <= '0;
                r_run_off <= req_addr[OFF_W-1:0];
            end

            // AW fields live only while AWVALID is up, so they read 0 elsewhere.
            if (w_accept && !w_req_err) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= req_addr;
                r_awlen   <= 8'(w_len_clamped);
                r_awsize  <= req_size;
                r_awburst <= AXI_BURST_INCR;
                r_awid    <= ID_W'(TXN_ID);
            end else if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_awaddr  <= '0;
                r_awlen   <= '0;
                r_awsize  <= '0;
                r_awburst <= '0;
                r_awid    <= '0;
            end

            if (w_w_hs) begin
                r_cnt     <= r_cnt + 1'b1;
                r_run_off <= r_run_off + OFF_W'(32'd1 << r_size);
            end

            r_done <= w_b_hs || ((r_state == ST_RESP) && r_err);
            if (w_b_hs) begin
                r_done_resp <= (BID != ID_W'(TXN_ID)) ? AXI_RESP_SLVERR : BRESP;
            end else if ((r_state == ST_RESP) && r_err) begin
                r_done_resp <= AXI_RESP_SLVERR;
            end else begin
                r_done_resp <= AXI_RESP_OKAY;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign AWVALID   = r_awvalid;
    assign AWADDR    = r_awaddr;
    assign AWLEN     = r_awlen;
    assign AWSIZE    = r_awsize;
    assign AWBURST   = r_awburst;
    assign AWID      = r_awid;
    assign BREADY    = r_bready;
    assign done      = r_done;
    assign done_resp = r_done_resp;

endmodule

// File: tb/tb_axi_wr_master.sv
// Directed bench for axi_wr_master: a table of single-transaction vectors
// plus hand-written sequences for stalls, narrow bursts and mid-burst reset.
module tb_axi_wr_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        req_len = '0;
    logic [2:0]        req_size = '0;
    logic              wd_valid = 1'b0;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data = '0;
    logic              done;
    logic [1:0]        done_resp;
    logic              AWVALID;
    logic              AWREADY = 1'b0;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic [ID_W-1:0]   AWID;
    logic              WVALID;
    logic              WREADY = 1'b0;
    logic [DATA_W-1:0] WDATA;
    logic [7:0]        WSTRB;
    logic              WLAST;
    logic              BVALID = 1'b0;
    logic              BREADY;
    logic [1:0]        BRESP = '0;
    logic [ID_W-1:0]   BID = '0;

    always #5 ACLK = ~ACLK;

    axi_wr_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_BEATS(16), .TXN_ID(0)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .done(done), .done_resp(done_resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_output_high();
        return |{req_ready, AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, WVALID, WDATA,
                 WSTRB, WLAST, BREADY, wd_ready, done, done_resp};
    endfunction

    // Transaction configuration and observed results
    logic [31:0] cfg_addr;
    logic [7:0]  cfg_len;
    logic [2:0]  cfg_size;
    logic [1:0]  cfg_bresp;
    logic [3:0]  cfg_bid;
    int          cfg_aw_delay;
    bit          cfg_toggle;

    int          res_aw_cycles, res_aw_unstable, res_w_early, res_beats;
    int          res_last_idx, res_last_cnt, res_wdata_bad, res_done_iter;
    logic [31:0] res_awaddr;
    logic [7:0]  res_awlen;
    logic [2:0]  res_awsize;
    logic [1:0]  res_awburst;
    logic [3:0]  res_awid;
    logic [7:0]  res_strb [0:255];
    bit          res_done_seen;
    logic [1:0]  res_done_resp;
    logic        res_rdy_at_done;

    task automatic run_txn();
        bit aw_done   = 1'b0;
        bit last_done = 1'b0;
        bit b_done    = 1'b0;
        int data_iter = 0;
        res_aw_cycles = 0; res_aw_unstable = 0; res_w_early = 0; res_beats = 0;
        res_last_idx = -1; res_last_cnt = 0; res_wdata_bad = 0; res_done_iter = 0;
        res_done_seen = 1'b0; res_done_resp = 2'bxx; res_rdy_at_done = 1'bx;
        @(negedge ACLK);
        req_valid = 1'b1; req_addr = cfg_addr; req_len = cfg_len; req_size = cfg_size;
        #1;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(negedge ACLK);
        req_valid = 1'b0;
        for (int it = 1; it <= 600 && !res_done_seen; it++) begin
            AWREADY  = (res_aw_cycles >= cfg_aw_delay);
            WREADY   = cfg_toggle ? (data_iter % 2 == 0) : 1'b1;
            wd_valid = 1'b1;
            wd_data  = 64'hD00D_0000_0000_0000 | 64'(res_beats);
            BVALID   = last_done && !b_done;
            BID      = cfg_bid;
            BRESP    = cfg_bresp;
            #1;
            if (done) begin
                res_done_seen = 1'b1; res_done_resp = done_resp;
                res_done_iter = it;   res_rdy_at_done = req_ready;
            end
            if (AWVALID) begin
                if (res_aw_cycles == 0) begin
                    res_awaddr = AWADDR; res_awlen = AWLEN; res_awsize = AWSIZE;
                    res_awburst = AWBURST; res_awid = AWID;
                end else if ({AWADDR, AWLEN, AWSIZE, AWBURST, AWID} !==
                             {res_awaddr, res_awlen, res_awsize, res_awburst, res_awid}) begin
                    res_aw_unstable++;
                end
                res_aw_cycles++;
            end
            if (WVALID && !aw_done) res_w_early++;
            if (WVALID && WREADY) begin
                if (res_beats < 256) res_strb[res_beats] = WSTRB;
                if (WDATA !== wd_data) res_wdata_bad++;
                if (WLAST) begin
                    if (res_last_cnt == 0) res_last_idx = res_beats;
                    res_last_cnt++;
                    last_done = 1'b1;
                end
                res_beats++;
            end
            if (BVALID && BREADY) b_done = 1'b1;
            if (aw_done) data_iter++;
            if (AWVALID && AWREADY) aw_done = 1'b1;
            @(negedge ACLK);
        end
        #1;
        check("done_seen", 64'(res_done_seen), 64'd1);
        check("done_one_cycle", 64'(done), 64'd0);
        AWREADY = 1'b0; WREADY = 1'b0; wd_valid = 1'b0; BVALID = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  bresp;
        logic [3:0]  bid;
        logic [7:0]  exp_awlen;
        logic [7:0]  exp_strb0;
        logic [7:0]  exp_strb_last;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n_done_rst;
        vecs[0] = '{32'h8000_0004, 8'd0,  3'd2, 2'b00, 4'd0, 8'd0,  8'hF0, 8'hF0, 2'b00};
        vecs[1] = '{32'h8000_0006, 8'd0,  3'd2, 2'b00, 4'd0, 8'd0,  8'hF0, 8'hF0, 2'b00};
        vecs[2] = '{32'h8000_0010, 8'd1,  3'd1, 2'b01, 4'd0, 8'd1,  8'h03, 8'h0C, 2'b01};
        vecs[3] = '{32'h8000_0100, 8'd0,  3'd3, 2'b00, 4'd5, 8'd0,  8'hFF, 8'hFF, 2'b10};
        vecs[4] = '{32'h8000_0020, 8'd40, 3'd2, 2'b11, 4'd0, 8'd15, 8'h0F, 8'hF0, 2'b11};
        vecs[5] = '{32'h8000_0003, 8'd2,  3'd0, 2'b10, 4'd0, 8'd2,  8'h08, 8'h20, 2'b10};

        // Reset state
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_outputs_zero", 64'(any_output_high()), 64'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        #1;
        check("rst_ready_after_release", 64'(req_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            cfg_addr = vecs[i].addr; cfg_len = vecs[i].len; cfg_size = vecs[i].size;
            cfg_bresp = vecs[i].bresp; cfg_bid = vecs[i].bid;
            cfg_aw_delay = 0; cfg_toggle = 1'b0;
            run_txn();
            check($sformatf("v%0d_awaddr", i), 64'(res_awaddr), 64'(vecs[i].addr));
            check($sformatf("v%0d_awlen", i), 64'(res_awlen), 64'(vecs[i].exp_awlen));
            check($sformatf("v%0d_awsize", i), 64'(res_awsize), 64'(vecs[i].size));
            check($sformatf("v%0d_awburst", i), 64'(res_awburst), 64'd1);
            check($sformatf("v%0d_awid", i), 64'(res_awid), 64'd0);
            check($sformatf("v%0d_beats", i), 64'(res_beats), 64'(vecs[i].exp_awlen) + 64'd1);
            check($sformatf("v%0d_strb_first", i), 64'(res_strb[0]), 64'(vecs[i].exp_strb0));
            check($sformatf("v%0d_strb_last", i),
                  (res_beats > 0 && res_beats <= 256) ? 64'(res_strb[res_beats-1]) : 64'hDEAD,
                  64'(vecs[i].exp_strb_last));
            check($sformatf("v%0d_wlast_idx", i), 64'(res_last_idx), 64'(vecs[i].exp_awlen));
            check($sformatf("v%0d_wlast_cnt", i), 64'(res_last_cnt), 64'd1);
            check($sformatf("v%0d_wdata", i), 64'(res_wdata_bad), 64'd0);
            check($sformatf("v%0d_done_resp", i), 64'(res_done_resp), 64'(vecs[i].exp_resp));
            check($sformatf("v%0d_latency", i), 64'(res_done_iter), 64'(vecs[i].exp_awlen) + 64'd4);
            check($sformatf("v%0d_ready_at_done", i), 64'(res_rdy_at_done), 64'd1);
            $display("txn v%0d addr=%h len=%0d size=%0d beats=%0d resp=%0d",
                     i, vecs[i].addr, vecs[i].len, vecs[i].size, res_beats, res_done_resp);
        end

        // Full-width burst with WREADY toggling
        cfg_addr = 32'h8000_1000; cfg_len = 8'd3; cfg_size = 3'd3; cfg_bresp = 2'b00;
        cfg_bid = 4'd0; cfg_aw_delay = 0; cfg_toggle = 1'b1;
        run_txn();
        check("burst_beats", 64'(res_beats), 64'd4);
        for (int b = 0; b < 4; b++) check($sformatf("burst_strb%0d", b), 64'(res_strb[b]), 64'hFF);
        check("burst_wlast_idx", 64'(res_last_idx), 64'd3);
        check("burst_wlast_cnt", 64'(res_last_cnt), 64'd1);
        $display("txn burst_toggle beats=%0d resp=%0d", res_beats, res_done_resp);

        // Byte-wide burst: strobe walks across all lanes
        cfg_addr = 32'h8000_2000; cfg_len = 8'd7; cfg_size = 3'd0; cfg_toggle = 1'b0;
        run_txn();
        check("narrow_beats", 64'(res_beats), 64'd8);
        for (int b = 0; b < 8; b++) check($sformatf("narrow_strb%0d", b), 64'(res_strb[b]), 64'd1 << b);
        $display("txn narrow beats=%0d resp=%0d", res_beats, res_done_resp);

        // AWREADY held low for five cycles
        cfg_addr = 32'h8000_4008; cfg_len = 8'd1; cfg_size = 3'd3; cfg_aw_delay = 5;
        run_txn();
        check("awstall_cycles", 64'(res_aw_cycles), 64'd6);
        check("awstall_unstable", 64'(res_aw_unstable), 64'd0);
        check("awstall_w_early", 64'(res_w_early), 64'd0);
        check("awstall_awaddr", 64'(res_awaddr), 64'h8000_4008);
        check("awstall_beats", 64'(res_beats), 64'd2);
        $display("txn aw_stall aw_cycles=%0d beats=%0d", res_aw_cycles, res_beats);
        cfg_aw_delay = 0;

        // Reset during beat 2 of a 4-beat burst
        @(negedge ACLK);
        req_valid = 1'b1; req_addr = 32'h8000_3000; req_len = 8'd3; req_size = 3'd3;
        AWREADY = 1'b1; WREADY = 1'b1; wd_valid = 1'b1; wd_data = 64'h1234_5678_9ABC_DEF0;
        @(negedge ACLK);
        req_valid = 1'b0;
        #1;
        check("rm_awvalid", 64'(AWVALID), 64'd1);
        @(negedge ACLK);
        #1;
        check("rm_beat1_wvalid", 64'(WVALID), 64'd1);
        @(negedge ACLK);
        #1;
        check("rm_beat2_wvalid", 64'({WVALID, WLAST}), 64'b10);
        ARESETn = 1'b0; BVALID = 1'b1; BID = 4'd0; BRESP = 2'b00;
        @(negedge ACLK);
        #1;
        check("rm_outputs_zero", 64'(any_output_high()), 64'd0);
        n_done_rst = 0;
        repeat (3) begin
            @(negedge ACLK);
            #1;
            if (done || BREADY) n_done_rst++;
        end
        check("rm_no_done", 64'(n_done_rst), 64'd0);
        ARESETn = 1'b1; BVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; wd_valid = 1'b0;
        @(negedge ACLK);
        #1;
        check("rm_ready_after", 64'(req_ready), 64'd1);
        $display("txn reset_mid_burst aborted");
        cfg_addr = 32'h8000_5000; cfg_len = 8'd0; cfg_size = 3'd3;
        cfg_bresp = 2'b00; cfg_bid = 4'd0; cfg_toggle = 1'b0;
        run_txn();
        check("rm_recover_beats", 64'(res_beats), 64'd1);
        check("rm_recover_resp", 64'(res_done_resp), 64'd0);
        $display("txn recover beats=%0d resp=%0d", res_beats, res_done_resp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
